// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch sequencer state encoding and PC reset value.
package pipeline_pkg;

  // Width of the fetch sequencer state register.
  localparam int unsigned FETCH_ST_W = 2;

  // Value the PC (and fetch-side address/instruction buffers) take on reset.
  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  // Fetch sequencer states.
  //   FETCH_REQ    : requesting the instruction at PCF.
  //   FETCH_HOLD   : returned instruction buffered while decode is stalled.
  //   FETCH_SQUASH : wrong-path request still outstanding after a redirect.
  typedef enum logic [FETCH_ST_W-1:0] {
    FETCH_REQ    = 2'd0,
    FETCH_HOLD   = 2'd1,
    FETCH_SQUASH = 2'd2
  } fetch_state_e;

  // Even parity over a 32-bit word, for buffers that want a cheap integrity bit.
  function automatic logic parity32(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter: clears synchronously, increments on inc_i and
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, otherwise step up unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = CNT_ZERO;
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge CLK) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer between the IF stage and a variable-latency instruction
// memory. Drives the request handshake, generates StallF, qualifies InstrF
// with InstrValidF, squashes wrong-path returns after a redirect and buffers
// a returned instruction while decode is stalled so memory is not re-read.
//
// Optional build macro FETCH_CTRL_PERF_EN adds perf_stall_cyc (cycles with
// StallF=1 outside reset) and perf_squash (discarded returns), both saturating.
module fetch_ctrl
  import pipeline_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        PCSrcE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        StallF,
  output logic [31:0] InstrF,
  output logic        InstrValidF
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [15:0] perf_squash
`endif
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  addr_q;
  logic [31:0]  addr_d;
  logic [31:0]  hold_q;
  logic [31:0]  hold_d;
  logic         discard_s;

  // Next state, buffer updates and the combinational fetch outputs.
  // Defaults describe a safe "request PCF, stall, nothing valid" cycle, which
  // is also exactly what the outputs must show while reset is asserted.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    imem_req    = 1'b1;
    imem_addr   = PCF;
    InstrF      = imem_rdata;
    StallF      = 1'b1;
    InstrValidF = 1'b0;
    discard_s   = 1'b0;

    if (reset) begin
      // Reset wins over any ack arriving in the same cycle.
      state_d = FETCH_REQ;
      addr_d  = PC_RESET;
      hold_d  = PC_RESET;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          // Remember the address in case a redirect leaves it outstanding.
          addr_d = PCF;
          if (PCSrcE) begin
            // Redirect: let the PC load the target; the current fetch is wrong-path.
            StallF = 1'b0;
            if (imem_ack) begin
              discard_s = 1'b1;
              state_d   = FETCH_REQ;
            end else begin
              state_d = FETCH_SQUASH;
            end
          end else if (imem_ack) begin
            if (StallD) begin
              // Decode busy: park the instruction and stop requesting.
              hold_d  = imem_rdata;
              state_d = FETCH_HOLD;
            end else begin
              InstrValidF = 1'b1;
              StallF      = 1'b0;
              state_d     = FETCH_REQ;
            end
          end else begin
            // Memory still busy: keep PCF (and so imem_addr) stable.
            state_d = FETCH_REQ;
          end
        end

        FETCH_HOLD: begin
          imem_req = 1'b0;
          InstrF   = hold_q;
          if (PCSrcE) begin
            // Buffered instruction is wrong-path; drop it and fetch the target.
            StallF  = 1'b0;
            state_d = FETCH_REQ;
          end else if (!StallD) begin
            InstrValidF = 1'b1;
            StallF      = 1'b0;
            state_d     = FETCH_REQ;
          end else begin
            state_d = FETCH_HOLD;
          end
        end

        FETCH_SQUASH: begin
          // Keep presenting the stale address until memory returns it; a
          // newer redirect still releases the PC register.
          imem_addr = addr_q;
          StallF    = !PCSrcE;
          if (imem_ack) begin
            discard_s = 1'b1;
            state_d   = FETCH_REQ;
          end else begin
            state_d = FETCH_SQUASH;
          end
        end

        default: begin
          // Unreachable encoding: recover into a clean request.
          state_d = FETCH_REQ;
        end
      endcase
    end
  end

  // Sequencer state, stale-address and hold buffers.
  always_ff @(posedge CLK) begin
    state_q <= state_d;
    addr_q  <= addr_d;
    hold_q  <= hold_d;
  end

`ifdef FETCH_CTRL_PERF_EN
  logic stall_cnt_inc_s;

  // A stall cycle counts only when not in reset.
  always_comb begin
    stall_cnt_inc_s = StallF & ~reset;
  end

  sat_counter #(
    .W (32)
  ) u_stall_cnt (
    .CLK     (CLK),
    .clear_i (reset),
    .inc_i   (stall_cnt_inc_s),
    .count_o (perf_stall_cyc)
  );

  sat_counter #(
    .W (16)
  ) u_squash_cnt (
    .CLK     (CLK),
    .clear_i (reset),
    .inc_i   (discard_s),
    .count_o (perf_squash)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// behavioural model of the fetch/decode contract and an in-order
// instruction-stream scoreboard. Also exercises sat_counter saturation.
module tb_fetch_ctrl;

  logic        CLK;
  logic        reset;
  logic [31:0] PCF;
  logic        PCSrcE;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        StallF;
  logic [31:0] InstrF;
  logic        InstrValidF;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [15:0] perf_squash;
`endif

  fetch_ctrl dut (
    .CLK         (CLK),
    .reset       (reset),
    .PCF         (PCF),
    .PCSrcE      (PCSrcE),
    .StallD      (StallD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .StallF      (StallF),
    .InstrF      (InstrF),
    .InstrValidF (InstrValidF)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_squash    (perf_squash)
`endif
  );

  logic       sc_clear;
  logic       sc_inc;
  logic [3:0] sc_count;

  sat_counter #(.W(4)) u_sat (
    .CLK     (CLK),
    .clear_i (sc_clear),
    .inc_i   (sc_inc),
    .count_o (sc_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory contents: distinct word per address, one fixed instruction at 0x4.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h2402000A;
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234} + 32'h0000_0101;
  endfunction

  // Environment state: PC register and memory latency counter.
  logic        rst_prev = 1'b1;
  logic        stall_prev = 1'b1;
  logic        pcs_prev = 1'b0;
  logic [31:0] tgt_prev = 32'h0;
  logic [31:0] tgt_cur = 32'h0;
  logic        req_prev = 1'b0;
  logic        ack_prev = 1'b0;
  int          wait_cnt = 0;
  int          cur_lat = 1;
  int          lat_cfg = 1;

  // One clock cycle: advance the PC register and memory, apply new inputs,
  // let the memory answer the request, then record what the PC will see.
  task automatic step(input logic rst, input logic pcs, input logic sd, input logic [31:0] tgt);
    @(posedge CLK);
    #1;
    if (rst_prev) PCF = 32'h0;
    else if (!stall_prev) PCF = pcs_prev ? tgt_prev : PCF + 32'd4;
    if (rst_prev || !req_prev || ack_prev) begin
      wait_cnt = 0;
      cur_lat  = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
    end else begin
      wait_cnt++;
    end
    reset   = rst;
    PCSrcE  = pcs;
    StallD  = sd;
    tgt_cur = tgt;
    #1;
    imem_ack   = imem_req && ((wait_cnt + 1) >= cur_lat);
    imem_rdata = imem_ack ? memf(imem_addr) : $urandom();
    #1;
    rst_prev   = reset;
    stall_prev = StallF;
    pcs_prev   = PCSrcE;
    tgt_prev   = tgt_cur;
    req_prev   = imem_req;
    ack_prev   = imem_ack;
  endtask

  // Behavioural model, checked on every negedge.
  logic        m_buf = 1'b0;
  logic [31:0] m_buf_val = 32'h0;
  logic        m_stale = 1'b0;
  logic [31:0] m_stale_addr = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  logic        m_prev_pend = 1'b0;
  logic [31:0] m_prev_addr = 32'h0;

  initial begin
    logic        e_req, e_valid, e_stall;
    logic [31:0] e_addr, e_instr;
    forever begin
      @(negedge CLK);
      if (reset) begin
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, PCF);
        chk("rst_stallf", {31'd0, StallF}, 32'd1);
        chk("rst_valid", {31'd0, InstrValidF}, 32'd0);
        m_buf   = 1'b0;
        m_stale = 1'b0;
        exp_pc  = 32'h0;
      end else begin
        e_req  = !m_buf;
        e_addr = m_stale ? m_stale_addr : PCF;
        if (m_buf) begin
          e_instr = m_buf_val;
          e_valid = !StallD && !PCSrcE;
          e_stall = StallD && !PCSrcE;
        end else if (m_stale) begin
          e_instr = imem_rdata;
          e_valid = 1'b0;
          e_stall = !PCSrcE;
        end else begin
          e_instr = imem_rdata;
          e_valid = imem_ack && !PCSrcE && !StallD;
          e_stall = !PCSrcE && (!imem_ack || StallD);
        end
        chk("req", {31'd0, imem_req}, {31'd0, e_req});
        chk("addr", imem_addr, e_addr);
        chk("instr", InstrF, e_instr);
        chk("valid", {31'd0, InstrValidF}, {31'd0, e_valid});
        chk("stallf", {31'd0, StallF}, {31'd0, e_stall});
        if (m_prev_pend) chk("addr_stable", imem_addr, m_prev_addr);
        if (InstrValidF === 1'b1) begin
          chk("stream", InstrF, memf(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
        if (PCSrcE) exp_pc = tgt_cur;
        // Advance the model.
        if (m_buf) begin
          if (PCSrcE || !StallD) m_buf = 1'b0;
        end else if (m_stale) begin
          if (imem_ack) m_stale = 1'b0;
        end else if (PCSrcE) begin
          m_stale      = !imem_ack;
          m_stale_addr = PCF;
        end else if (imem_ack && StallD) begin
          m_buf     = 1'b1;
          m_buf_val = imem_rdata;
        end
      end
      m_prev_pend = !reset && imem_req && !imem_ack;
      m_prev_addr = imem_addr;
    end
  end

  initial begin
    reset = 1'b1; PCF = 32'h0; PCSrcE = 1'b0; StallD = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    sc_clear = 1'b1; sc_inc = 1'b0;

    // Reset, then zero-wait streaming.
    lat_cfg = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("reset_stallf", {31'd0, StallF}, 32'd1);
    chk("reset_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("zw_addr", imem_addr, 32'(i * 4));
      chk("zw_valid", {31'd0, InstrValidF}, 32'd1);
      chk("zw_stallf", {31'd0, StallF}, 32'd0);
`ifdef FETCH_CTRL_PERF_EN
      if (i == 0) chk("perf_clr", perf_stall_cyc, 32'd0);
`endif
    end

    // Wait states: ack in the 3rd request cycle for PCF=0.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    lat_cfg = 3;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ws_c1_stallf", {31'd0, StallF}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ws_c2_stallf", {31'd0, StallF}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ws_c3_valid", {31'd0, InstrValidF}, 32'd1);
    chk("ws_c3_instr", InstrF, memf(32'h0));

    // Decode stall for two cycles on the instruction at 0x4.
    lat_cfg = 1;
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("ws_next_addr", imem_addr, 32'h4);
    chk("ds_c1_stallf", {31'd0, StallF}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("ds_c2_req", {31'd0, imem_req}, 32'd0);
    chk("ds_c2_stallf", {31'd0, StallF}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ds_rel_instr", InstrF, 32'h2402000A);
    chk("ds_rel_valid", {31'd0, InstrValidF}, 32'd1);
    chk("ds_rel_req", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ds_after_addr", imem_addr, 32'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect while the fetch of 0x10 is outstanding; ack in its 3rd cycle.
    lat_cfg = 3;
    step(1'b0, 1'b1, 1'b0, 32'h40);
    chk("rd_c1_addr", imem_addr, 32'h10);
    chk("rd_c1_stallf", {31'd0, StallF}, 32'd0);
    chk("rd_c1_valid", {31'd0, InstrValidF}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rd_c2_addr", imem_addr, 32'h10);
    chk("rd_c2_valid", {31'd0, InstrValidF}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rd_c3_ack", {31'd0, imem_ack}, 32'd1);
    chk("rd_c3_addr", imem_addr, 32'h10);
    chk("rd_c3_valid", {31'd0, InstrValidF}, 32'd0);
    lat_cfg = 1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rd_c4_addr", imem_addr, 32'h40);
    chk("rd_c4_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_CTRL_PERF_EN
    chk("perf_squash", {16'd0, perf_squash}, 32'd1);
    chk("perf_stall", perf_stall_cyc, 32'd6);
`endif

    // Redirect while an instruction is held for a stalled decode.
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    chk("rh_valid", {31'd0, InstrValidF}, 32'd0);
    chk("rh_stallf", {31'd0, StallF}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rh_addr", imem_addr, 32'h100);
    chk("rh_instr", InstrF, memf(32'h100));

    // Randomized traffic: latency, decode stalls, redirects, rare resets.
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 30),
           32'($urandom_range(0, 255)) << 2);
    end

    // Saturating counter: counts up, sticks at all-ones, clear wins.
    sc_clear = 1'b1; sc_inc = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    sc_clear = 1'b0; sc_inc = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("sat_mid", {28'd0, sc_count}, 32'd5);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("sat_max", {28'd0, sc_count}, 32'd15);
    sc_clear = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("sat_clear", {28'd0, sc_count}, 32'd0);
    sc_clear = 1'b0; sc_inc = 1'b0;

    #10;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
